// File: rtl/mdu_iter_pkg.sv
// rtl/mdu_iter_pkg.sv - shared multiply/divide operation codes
package mdu_iter_pkg;

    // mdop encodings shared with the decoder; 0 and 7 are no-ops
    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // True for the codes that run the iterative datapath
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the codes that work on two's-complement operands
    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// rtl/mdu_iter_core.sv - one-step shift-add / restoring-divide datapath
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic [2*WIDTH-1:0]   acc
);

    // acc_q: multiply = {partial product, remaining multiplier bits};
    //        divide   = {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;

    // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = shifted - {1'b0, opb_q};
        acc_next = {sum, acc_q[WIDTH-1:1]};
        if (mode) begin
            // diff[WIDTH] set means the trial subtract borrowed: restore
            if (diff[WIDTH]) begin
                acc_next = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // Operand load on start, one step per enabled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            opb_q <= '0;
        end else if (load) begin
            acc_q <= {{WIDTH{1'b0}}, opa};
            opb_q <= opb;
        end else if (step) begin
            acc_q <= acc_next;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               load, step, wr_res, accept;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Signed ops feed magnitudes to the unsigned datapath; signs are restored in FIX
    always_comb begin
        signed_op = op_is_signed(mdop);
        a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
        accept    = (state == S_IDLE) && start && !flush;
    end

    // Sign fixup: quotient/product negate on differing signs, remainder follows dividend
    always_comb begin
        prod_fix = neg_res ? -acc : acc;
        quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Next-state and datapath controls; flush abandons RUN/FIX without writing
    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        wr_res  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && op_is_arith(mdop)) begin
                    load    = 1'b1;
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        state_n = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                wr_res  = !flush;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register, step counter, latched sign flags and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_n;
            done  <= wr_res;
            if (load) begin
                cnt     <= CW'(WIDTH - 1);
                is_div  <= (mdop == MD_DIV) || (mdop == MD_DIVU);
                neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= signed_op && a[WIDTH-1];
            end else if (step) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // HI/LO: result write from FIX, or direct MTHI/MTLO write from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_res) begin
            if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end else if (accept) begin
            if (mdop == MD_MTHI) hi <= a;
            if (mdop == MD_MTLO) lo <= a;
        end
    end

    assign busy = (state != S_IDLE);

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .mode (is_div),
        .opa  (a_mag),
        .opb  (b_mag),
        .acc  (acc)
    );

endmodule
